// File: rtl/frequency_window_controller.sv
// Purpose : sequences one frequency analyzer through clear / measure / flush / capture windows
//           and turns each window's f0/f1/unknown tick totals into a symbol decision.
// Latency : result_valid rises CLEAR_TICKS+WINDOW_TICKS+FLUSH_TICKS+1 cycles after the edge sampling start.
// Backpressure: result held until result_valid&result_ready; a capture onto an unaccepted
//           result overwrites it and sets the sticky overrun flag.
//
// Ports:
//   clock, clear        rising-edge clock, asynchronous active-low reset
//   start, continuous   begin a window (ignored while busy); auto-restart after each capture
//   abort               cancel the current window, no result produced
//   f0_value, f1_value, unknown      live analyzer accumulators
//   analyzer_enable, analyzer_clear  analyzer controls (clear is active-low)
//   busy                FSM not idle
//   result_valid/result_ready        result handshake
//   f0_total, f1_total, unknown_total, decision, overrun   latched window result
module frequency_window_controller #(
    parameter int unsigned WINDOW_TICKS      = 1000,
    parameter int unsigned CLEAR_TICKS       = 2,
    parameter int unsigned FLUSH_TICKS       = 2,
    parameter int unsigned MIN_VALID_PERCENT = 50
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        continuous,
    input  logic        abort,
    input  logic [31:0] f0_value,
    input  logic [31:0] f1_value,
    input  logic [31:0] unknown,
    output logic        analyzer_enable,
    output logic        analyzer_clear,
    output logic        busy,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [31:0] f0_total,
    output logic [31:0] f1_total,
    output logic [31:0] unknown_total,
    output logic [1:0]  decision,
    output logic        overrun
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    // Counters are loaded with (ticks-1) on state entry and the state is left
    // on the cycle the counter reads zero, giving exactly <ticks> cycles.
    localparam logic [31:0] CLEAR_LOAD  = 32'(CLEAR_TICKS - 1);
    localparam logic [31:0] WINDOW_LOAD = 32'(WINDOW_TICKS - 1);
    localparam logic [31:0] FLUSH_LOAD  = 32'(FLUSH_TICKS - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        abort_pend_q, abort_pend_d;
    logic        analyzer_enable_q, analyzer_enable_d;
    logic        analyzer_clear_q, analyzer_clear_d;
    logic        busy_q, busy_d;
    logic        result_valid_q, result_valid_d;
    logic [31:0] f0_total_q, f0_total_d;
    logic [31:0] f1_total_q, f1_total_d;
    logic [31:0] unknown_total_q, unknown_total_d;
    logic [1:0]  decision_q, decision_d;
    logic        overrun_q, overrun_d;

    // Decision datapath: sum fits 34 bits; scaled comparisons need 41 bits
    // (2^34 * 100 < 2^41) so no intermediate overflows.
    logic [33:0] sum;
    logic [31:0] winner;
    logic [40:0] win_scaled;
    logic [40:0] sum_scaled;
    logic [1:0]  window_decision;

    always_comb begin
        sum        = {2'b00, f0_value} + {2'b00, f1_value} + {2'b00, unknown};
        winner     = (f0_value > f1_value) ? f0_value : f1_value;
        win_scaled = 41'(winner) * 41'd100;
        sum_scaled = 41'(sum) * 41'(MIN_VALID_PERCENT);
        window_decision = 2'd0;
        if (sum == 34'd0) begin
            window_decision = 2'd0;
        end else if ((f0_value == f1_value) && (f0_value != 32'd0)) begin
            window_decision = 2'd3;
        end else if (win_scaled >= sum_scaled) begin
            window_decision = (f0_value > f1_value) ? 2'd1 : 2'd2;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        abort_pend_d    = abort_pend_q;
        f0_total_d      = f0_total_q;
        f1_total_d      = f1_total_q;
        unknown_total_d = unknown_total_q;
        decision_d      = decision_q;
        overrun_d       = overrun_q;
        // Handshake consumes the result; a capture below may reload it.
        result_valid_d  = result_valid_q && !result_ready;

        if (state_q == ST_IDLE) begin
            // abort beats start even while idle: nothing starts.
            if (start && !abort) begin
                state_d      = ST_CLEAR;
                cnt_d        = CLEAR_LOAD;
                abort_pend_d = 1'b0;
            end
        end else if (abort) begin
            // Leave the analyzer cleared for a full clear period, then idle.
            state_d      = ST_CLEAR;
            cnt_d        = CLEAR_LOAD;
            abort_pend_d = 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (cnt_q == 32'd0) begin
                        if (abort_pend_q) begin
                            state_d      = ST_IDLE;
                            abort_pend_d = 1'b0;
                        end else begin
                            state_d = ST_MEASURE;
                            cnt_d   = WINDOW_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                ST_MEASURE: begin
                    if (cnt_q == 32'd0) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == 32'd0) begin
                        state_d = ST_CAPTURE;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                ST_CAPTURE: begin
                    f0_total_d      = f0_value;
                    f1_total_d      = f1_value;
                    unknown_total_d = unknown;
                    decision_d      = window_decision;
                    result_valid_d  = 1'b1;
                    // A simultaneous accept consumed the old result, so only
                    // an unaccepted result counts as overwritten.
                    if (result_valid_q && !result_ready) begin
                        overrun_d = 1'b1;
                    end
                    if (continuous) begin
                        state_d = ST_CLEAR;
                        cnt_d   = CLEAR_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 32'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 32'd0;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        analyzer_enable_d = (state_d == ST_MEASURE);
        analyzer_clear_d  = (state_d != ST_CLEAR);
        busy_d            = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q           <= ST_IDLE;
            cnt_q             <= 32'd0;
            abort_pend_q      <= 1'b0;
            analyzer_enable_q <= 1'b0;
            analyzer_clear_q  <= 1'b0;
            busy_q            <= 1'b0;
            result_valid_q    <= 1'b0;
            f0_total_q        <= 32'd0;
            f1_total_q        <= 32'd0;
            unknown_total_q   <= 32'd0;
            decision_q        <= 2'd0;
            overrun_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            abort_pend_q      <= abort_pend_d;
            analyzer_enable_q <= analyzer_enable_d;
            analyzer_clear_q  <= analyzer_clear_d;
            busy_q            <= busy_d;
            result_valid_q    <= result_valid_d;
            f0_total_q        <= f0_total_d;
            f1_total_q        <= f1_total_d;
            unknown_total_q   <= unknown_total_d;
            decision_q        <= decision_d;
            overrun_q         <= overrun_d;
        end
    end

    assign analyzer_enable = analyzer_enable_q;
    assign analyzer_clear  = analyzer_clear_q;
    assign busy            = busy_q;
    assign result_valid    = result_valid_q;
    assign f0_total        = f0_total_q;
    assign f1_total        = f1_total_q;
    assign unknown_total   = unknown_total_q;
    assign decision        = decision_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_frequency_window_controller.sv
module tb_frequency_window_controller;

    logic        clock;
    logic        clear_n;
    logic        start;
    logic        continuous;
    logic        abort;
    logic [31:0] f0_value;
    logic [31:0] f1_value;
    logic [31:0] unknown;
    logic        analyzer_enable;
    logic        analyzer_clear;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] f0_total;
    logic [31:0] f1_total;
    logic [31:0] unknown_total;
    logic [1:0]  decision;
    logic        overrun;

    frequency_window_controller dut (
        .clock           (clock),
        .clear           (clear_n),
        .start           (start),
        .continuous      (continuous),
        .abort           (abort),
        .f0_value        (f0_value),
        .f1_value        (f1_value),
        .unknown         (unknown),
        .analyzer_enable (analyzer_enable),
        .analyzer_clear  (analyzer_clear),
        .busy            (busy),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .f0_total        (f0_total),
        .f1_total        (f1_total),
        .unknown_total   (unknown_total),
        .decision        (decision),
        .overrun         (overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] f0;
        logic [31:0] f1;
        logic [31:0] unk;
        logic [1:0]  dec;
    } vec_t;

    localparam int NVEC = 15;
    vec_t tbl [NVEC];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Pulses start (edge 0), then waits for result_valid, counting edges and
    // the cycles enable was high / clear was low. lat = bound on timeout.
    task automatic run_window(input int bound, output int lat, output int en_cnt, output int clr_cnt);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        lat     = 0;
        en_cnt  = analyzer_enable ? 1 : 0;
        clr_cnt = analyzer_clear ? 0 : 1;
        while (!result_valid && lat < bound) begin
            tick(1);
            lat++;
            if (analyzer_enable) en_cnt++;
            if (!analyzer_clear) clr_cnt++;
        end
    endtask

    task automatic set_vals(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        f0_value = a;
        f1_value = b;
        unknown  = c;
    endtask

    int lat, en_cnt, clr_cnt, vcnt;

    initial begin
        tbl[0]  = '{32'd600, 32'd100, 32'd300, 2'd1};
        tbl[1]  = '{32'd300, 32'd200, 32'd500, 2'd0};
        tbl[2]  = '{32'd400, 32'd400, 32'd200, 2'd3};
        tbl[3]  = '{32'd0,   32'd0,   32'd0,   2'd0};
        tbl[4]  = '{32'd100, 32'd700, 32'd200, 2'd2};
        tbl[5]  = '{32'd500, 32'd100, 32'd400, 2'd1};   // exactly 50 %
        tbl[6]  = '{32'd499, 32'd100, 32'd401, 2'd0};   // just below
        tbl[7]  = '{32'hFFFFFFFF, 32'd0, 32'd0, 2'd1};
        tbl[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3};
        tbl[9]  = '{32'd0,   32'd0,   32'd5,   2'd0};   // equal but zero: not ambiguous
        tbl[10] = '{32'd0,   32'd1,   32'd0,   2'd2};
        tbl[11] = '{32'd10,  32'd30,  32'd30,  2'd0};   // 3000 < 3500
        tbl[12] = '{32'd10,  32'd40,  32'd30,  2'd2};   // 4000 >= 4000
        tbl[13] = '{32'h80000000, 32'd0, 32'h80000000, 2'd1}; // sum = 2^32, exact tie
        tbl[14] = '{32'h7FFFFFFF, 32'd0, 32'h80000001, 2'd0};

        clear_n = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
        result_ready = 1'b0;
        set_vals(32'd0, 32'd0, 32'd0);

        // ---- reset state ----
        #12;
        chk("rst analyzer_clear", 64'(analyzer_clear), 64'd0);
        chk("rst enable", 64'(analyzer_enable), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst valid", 64'(result_valid), 64'd0);
        chk("rst overrun", 64'(overrun), 64'd0);
        chk("rst decision", 64'(decision), 64'd0);
        chk("rst f0_total", 64'(f0_total), 64'd0);
        #10 clear_n = 1'b1;
        tick(1);
        chk("post-rst analyzer_clear", 64'(analyzer_clear), 64'd1);
        chk("post-rst busy", 64'(busy), 64'd0);

        // ---- table-driven windows ----
        for (int i = 0; i < NVEC; i++) begin
            set_vals(tbl[i].f0, tbl[i].f1, tbl[i].unk);
            run_window(1100, lat, en_cnt, clr_cnt);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd1005);
            chk($sformatf("vec%0d enable cycles", i), 64'(en_cnt), 64'd1000);
            chk($sformatf("vec%0d clear cycles", i), 64'(clr_cnt), 64'd2);
            chk($sformatf("vec%0d decision", i), 64'(decision), 64'(tbl[i].dec));
            chk($sformatf("vec%0d f0_total", i), 64'(f0_total), 64'(tbl[i].f0));
            chk($sformatf("vec%0d f1_total", i), 64'(f1_total), 64'(tbl[i].f1));
            chk($sformatf("vec%0d unknown_total", i), 64'(unknown_total), 64'(tbl[i].unk));
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'd0);
            result_ready = 1'b1;
            tick(1);
            result_ready = 1'b0;
            chk($sformatf("vec%0d accepted", i), 64'(result_valid), 64'd0);
            chk($sformatf("vec%0d overrun", i), 64'(overrun), 64'd0);
        end

        // ---- back-to-back continuous windows, ready held high ----
        set_vals(32'd600, 32'd100, 32'd300);
        result_ready = 1'b1;
        continuous = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        vcnt = 0;
        for (int e = 1; e <= 3100; e++) begin
            tick(1);
            if (result_valid) vcnt++;
            if (e == 2500) continuous = 1'b0;
        end
        chk("b2b valid pulses", 64'(vcnt), 64'd3);
        chk("b2b overrun", 64'(overrun), 64'd0);
        chk("b2b busy", 64'(busy), 64'd0);
        result_ready = 1'b0;

        // ---- capture coincident with accept ----
        set_vals(32'd600, 32'd100, 32'd300);
        continuous = 1'b1;
        run_window(1100, lat, en_cnt, clr_cnt);
        chk("coin first latency", 64'(lat), 64'd1005);
        continuous = 1'b0;
        set_vals(32'd100, 32'd700, 32'd200);
        tick(1004);                              // edge 2009
        chk("coin held valid", 64'(result_valid), 64'd1);
        chk("coin held f0_total", 64'(f0_total), 64'd600);
        result_ready = 1'b1;
        tick(1);                                 // edge 2010: capture + accept
        chk("coin valid", 64'(result_valid), 64'd1);
        chk("coin f1_total", 64'(f1_total), 64'd700);
        chk("coin decision", 64'(decision), 64'd2);
        chk("coin overrun", 64'(overrun), 64'd0);
        tick(1);
        result_ready = 1'b0;
        chk("coin accepted", 64'(result_valid), 64'd0);
        chk("coin busy", 64'(busy), 64'd0);

        // ---- start during FLUSH is ignored ----
        set_vals(32'd600, 32'd100, 32'd300);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1002);                              // edge 1002, FLUSH
        chk("flush enable", 64'(analyzer_enable), 64'd0);
        start = 1'b1;
        tick(1);                                 // edge 1003
        start = 1'b0;
        tick(2);                                 // edge 1005
        chk("flush-start valid", 64'(result_valid), 64'd1);
        result_ready = 1'b1;
        tick(1);
        result_ready = 1'b0;
        vcnt = 0;
        for (int e = 0; e < 1100; e++) begin
            tick(1);
            if (result_valid || busy) vcnt++;
        end
        chk("flush-start extra activity", 64'(vcnt), 64'd0);

        // ---- abort during MEASURE ----
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(300);                               // edge 300
        chk("abort pre enable", 64'(analyzer_enable), 64'd1);
        abort = 1'b1;
        tick(1);                                 // edge 301
        abort = 1'b0;
        chk("abort enable", 64'(analyzer_enable), 64'd0);
        chk("abort clear c1", 64'(analyzer_clear), 64'd0);
        chk("abort busy", 64'(busy), 64'd1);
        tick(1);
        chk("abort clear c2", 64'(analyzer_clear), 64'd0);
        tick(1);
        chk("abort clear released", 64'(analyzer_clear), 64'd1);
        chk("abort idle", 64'(busy), 64'd0);
        vcnt = 0;
        for (int e = 0; e < 1100; e++) begin
            tick(1);
            if (result_valid || analyzer_enable) vcnt++;
        end
        chk("abort no result", 64'(vcnt), 64'd0);
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        chk("idle start+abort busy", 64'(busy), 64'd0);
        chk("idle start+abort clear", 64'(analyzer_clear), 64'd1);

        // ---- overrun with ready low across two windows ----
        set_vals(32'd600, 32'd100, 32'd300);
        continuous = 1'b1;
        run_window(1100, lat, en_cnt, clr_cnt);
        chk("ovr first latency", 64'(lat), 64'd1005);
        chk("ovr first overrun", 64'(overrun), 64'd0);
        set_vals(32'd300, 32'd200, 32'd500);
        continuous = 1'b0;
        tick(1004);                              // edge 2009
        chk("ovr pre overrun", 64'(overrun), 64'd0);
        chk("ovr pre f0_total", 64'(f0_total), 64'd600);
        tick(1);                                 // edge 2010
        chk("ovr overrun", 64'(overrun), 64'd1);
        chk("ovr f0_total", 64'(f0_total), 64'd300);
        chk("ovr unknown_total", 64'(unknown_total), 64'd500);
        chk("ovr decision", 64'(decision), 64'd0);
        chk("ovr valid", 64'(result_valid), 64'd1);
        tick(1);
        chk("ovr busy", 64'(busy), 64'd0);
        chk("ovr sticky", 64'(overrun), 64'd1);

        // ---- reset mid-MEASURE (result still pending, overrun set) ----
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(500);
        chk("mid enable", 64'(analyzer_enable), 64'd1);
        #2 clear_n = 1'b0;
        #1;
        chk("mid-rst enable", 64'(analyzer_enable), 64'd0);
        chk("mid-rst analyzer_clear", 64'(analyzer_clear), 64'd0);
        chk("mid-rst busy", 64'(busy), 64'd0);
        chk("mid-rst valid", 64'(result_valid), 64'd0);
        chk("mid-rst overrun", 64'(overrun), 64'd0);
        chk("mid-rst decision", 64'(decision), 64'd0);
        chk("mid-rst totals", 64'(f0_total | unknown_total), 64'd0);
        #3 clear_n = 1'b1;
        tick(1);
        chk("mid-rel analyzer_clear", 64'(analyzer_clear), 64'd1);
        chk("mid-rel busy", 64'(busy), 64'd0);
        vcnt = 0;
        for (int e = 0; e < 1100; e++) begin
            tick(1);
            if (result_valid || busy) vcnt++;
        end
        chk("mid-rel no result", 64'(vcnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
